// File: rtl/clk_div_gen.sv
// Programmable clock-enable divider: emits a one-cycle tick every N enabled
// clocks and a 50% square wave toggling on each tick, with glitch-free reload.
module clk_div_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_out,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend_vld
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  logic [WIDTH-1:0] last_cnt_s;
  logic [WIDTH-1:0] next_div_s;
  logic             wrap_s;

  // Terminal count and the divisor that takes effect at the next period boundary.
  always_comb begin
    if (div_cur_q == ZERO) begin
      last_cnt_s = ZERO;
    end else begin
      last_cnt_s = div_cur_q - ONE;
    end
    wrap_s = en && (cnt_q == last_cnt_s);
    if (div_load) begin
      next_div_s = div_in;
    end else if (pend_vld_q) begin
      next_div_s = pend_q;
    end else begin
      next_div_s = div_cur_q;
    end
  end

  // Next-state logic: sclr beats wrap, wrap beats a plain count/load.
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    if (div_load) begin
      pend_d = div_in;
    end else begin
      pend_d = pend_q;
    end
    if (sclr) begin
      cnt_d      = ZERO;
      clk_out_d  = 1'b0;
      div_cur_d  = next_div_s;
      pend_vld_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d      = ZERO;
      tick_d     = 1'b1;
      clk_out_d  = ~clk_out_q;
      div_cur_d  = next_div_s;
      pend_vld_d = 1'b0;
    end else begin
      if (en) begin
        cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = cnt_q;
      end
      if (div_load) begin
        pend_vld_d = 1'b1;
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= ZERO;
      div_cur_q  <= DIV_RST;
      pend_q     <= ZERO;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign tick     = tick_q;
  assign clk_out  = clk_out_q;
  assign div_cur  = div_cur_q;
  assign pend_vld = pend_vld_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: a directed vector table, corner-case
// sequences and random stimulus against a countdown-based reference model.
module tb_clk_div_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sclr;
  logic [7:0] div_in;
  logic       div_load;
  logic       tick;
  logic       clk_out;
  logic [7:0] div_cur;
  logic       pend_vld;

  int pass_cnt  = 0;
  int total_cnt = 0;

  clk_div_gen #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .div_in(div_in),
    .div_load(div_load), .tick(tick), .clk_out(clk_out),
    .div_cur(div_cur), .pend_vld(pend_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycles remaining until the next tick, plus divisor bookkeeping.
  int m_rem, m_cur, m_pend;
  bit m_pv, m_tick, m_clk;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_cur = 4; m_pend = 0; m_pv = 0; m_tick = 0; m_clk = 0; m_rem = 4;
    end else if (sclr) begin
      m_cur  = div_load ? int'(div_in) : (m_pv ? m_pend : m_cur);
      m_pv   = 0;
      m_tick = 0;
      m_clk  = 0;
      m_rem  = eff(m_cur);
    end else if (en && m_rem == 1) begin
      m_cur  = div_load ? int'(div_in) : (m_pv ? m_pend : m_cur);
      m_pv   = 0;
      m_tick = 1;
      m_clk  = !m_clk;
      m_rem  = eff(m_cur);
    end else begin
      m_tick = 0;
      if (en) m_rem = m_rem - 1;
      if (div_load) begin
        m_pend = int'(div_in);
        m_pv   = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit r, input bit s, input bit e, input bit l, input int d);
    rst = r; sclr = s; en = e; div_load = l; div_in = 8'(d);
  endtask

  // One clock: update the model at the edge, compare outputs just after it.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model", {21'd0, tick, clk_out, pend_vld, div_cur},
          {21'd0, m_tick, m_clk, m_pv, 8'(m_cur)});
  endtask

  task automatic cycles_to_tick(output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      n++;
      if (tick) found = 1;
    end
    check("tick_found", {31'd0, found}, 32'd1);
  endtask

  task automatic do_reset();
    drive(1, 0, 1, 0, 0); step(); step();
    drive(0, 0, 1, 0, 0);
  endtask

  typedef struct {
    bit rst, sclr, en, ld;
    int din;
    bit tick, clko, pv;
    int cur;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit s, input bit e, input bit l, input int d,
                     input bit t, input bit c, input bit p, input int cu, input int rep);
    vec_t v;
    v = '{rst: r, sclr: s, en: e, ld: l, din: d, tick: t, clko: c, pv: p, cur: cu};
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endtask

  initial begin
    int n;
    bit prev_clk;
    drive(1, 0, 0, 0, 0);
    m_rem = 4; m_cur = 4; m_pend = 0; m_pv = 0; m_tick = 0; m_clk = 0;

    // Reset, default divisor 4, then a reload to 6 one cycle into a period.
    add(1, 0, 1, 0, 0, 0, 0, 0, 4, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 4, 3);
    add(0, 0, 1, 0, 0, 1, 1, 0, 4, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 4, 3);
    add(0, 0, 1, 0, 0, 1, 0, 0, 4, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 4, 3);
    add(0, 0, 1, 0, 0, 1, 1, 0, 4, 1);
    add(0, 0, 1, 1, 6, 0, 1, 1, 4, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1, 4, 2);
    add(0, 0, 1, 0, 0, 1, 0, 0, 6, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 6, 5);
    add(0, 0, 1, 0, 0, 1, 1, 0, 6, 1);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sclr, vecs[i].en, vecs[i].ld, vecs[i].din);
      step();
      check($sformatf("vec%0d", i), {21'd0, tick, clk_out, pend_vld, div_cur},
            {21'd0, vecs[i].tick, vecs[i].clko, vecs[i].pv, 8'(vecs[i].cur)});
    end

    // Enable gating: three frozen cycles delay the tick by exactly three.
    do_reset();
    cycles_to_tick(n);
    check("first_tick_n4", n, 4);
    step();
    prev_clk = clk_out;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gated_tick", {31'd0, tick}, 32'd0);
      check("gated_clk", {31'd0, clk_out}, {31'd0, prev_clk});
    end
    drive(0, 0, 1, 0, 0);
    cycles_to_tick(n);
    check("gated_delay", n, 3);

    // Divisors 0 and 1: tick held high, clk_out toggling every cycle.
    for (int d = 0; d < 2; d++) begin
      drive(0, 1, 1, 1, d);
      step();
      check("sclr_load_cur", {24'd0, div_cur}, d);
      check("sclr_clk", {31'd0, clk_out}, 32'd0);
      drive(0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
        prev_clk = clk_out;
        step();
        check($sformatf("div%0d_tick", d), {31'd0, tick}, 32'd1);
        check($sformatf("div%0d_toggle", d), {31'd0, clk_out}, {31'd0, !prev_clk});
      end
    end

    // sclr at cnt==2 with a pending divisor of 3.
    do_reset();
    cycles_to_tick(n);
    drive(0, 0, 1, 1, 3); step();
    drive(0, 0, 1, 0, 0); step();
    check("pend_before_sclr", {31'd0, pend_vld}, 32'd1);
    drive(0, 1, 1, 0, 0); step();
    check("sclr_clk_low", {31'd0, clk_out}, 32'd0);
    check("sclr_cur", {24'd0, div_cur}, 32'd3);
    check("sclr_pv", {31'd0, pend_vld}, 32'd0);
    drive(0, 0, 1, 0, 0);
    cycles_to_tick(n);
    check("sclr_next_tick", n, 3);

    // Reset while a divisor is pending discards it.
    cycles_to_tick(n);
    drive(0, 0, 1, 1, 7); step();
    check("pend_set", {31'd0, pend_vld}, 32'd1);
    drive(1, 0, 1, 0, 0); step();
    check("rst_cur", {24'd0, div_cur}, 32'd4);
    check("rst_pv", {31'd0, pend_vld}, 32'd0);
    drive(0, 0, 1, 0, 0);
    cycles_to_tick(n);
    check("rst_tick1", n, 4);
    cycles_to_tick(n);
    check("rst_tick2", n, 4);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, bit width of divisor and counter.
REQ-002 SHALL provide parameter DEFAULT_DIV, default 4, divisor loaded at reset (100 MHz to 25 MHz pixel enable).
REQ-003 SHALL provide port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port en  input  1  count enable; low freezes all state.
REQ-006 SHALL provide port sclr  input  1  synchronous phase restart; divisor retained.
REQ-007 SHALL provide port div_in  input  WIDTH  new divisor value.
REQ-008 SHALL provide port div_load  input  1  one-cycle strobe; captures div_in as pending divisor.
REQ-009 SHALL provide port tick  output  1  registered one-cycle pulse, once per divisor period.
REQ-010 SHALL provide port clk_out  output  1  registered square wave, toggles on each tick, period 2N, 50% duty.
REQ-011 SHALL provide port div_cur  output  WIDTH  divisor currently in effect.
REQ-012 SHALL provide port pend_vld  output  1  high while a loaded divisor awaits application.

Function
REQ-013 SHALL use effective divisor N = div_cur, with div_cur==0 treated as N=1.
REQ-014 SHALL keep internal counter cnt in range 0..N-1, incrementing by one per clock with en=1.
REQ-015 SHALL, on a clock with en=1 and cnt==N-1 (wrap), set cnt<=0, tick<=1, clk_out<=~clk_out.
REQ-016 SHALL drive tick<=0 on every clock that is not a wrap, so tick never exceeds one cycle when N>1.
REQ-017 SHALL, for N=1, assert tick continuously while en=1; clk_out toggles every enabled cycle.
REQ-018 SHALL, with en=0, hold cnt, clk_out, div_cur and the pending divisor, and drive tick<=0.
REQ-019 SHALL, on div_load=1, capture div_in into the pending register and set pend_vld<=1, regardless of en.
REQ-020 SHALL, on div_load while pend_vld=1, overwrite the pending value (last load wins).
REQ-021 SHALL apply the pending divisor only at a wrap: div_cur<=pending, pend_vld<=0; next period uses the new N.
REQ-022 SHALL, for div_load coincident with a wrap, apply div_in directly at that wrap and leave pend_vld=0.
REQ-023 SHALL never change div_cur mid-period, so no tick period is a mix of old and new N.
REQ-024 SHALL, on sclr=1 (rst=0), set cnt<=0, tick<=0, clk_out<=0, and apply any pending divisor immediately (pend_vld<=0); sclr has priority over en and wrap.
REQ-025 SHALL, for div_load coincident with sclr, apply div_in as div_cur at that edge.
REQ-026 SHALL give rst priority over sclr, div_load and en.

Reset
REQ-027 SHALL, on clock edge with rst=1, set cnt=0, tick=0, clk_out=0, div_cur=DEFAULT_DIV, pending=0, pend_vld=0.
REQ-028 SHALL, with rst held high, keep all outputs at reset values; the first tick follows exactly N enabled clocks after rst deasserts.
REQ-029 SHALL discard a pending divisor and restart the phase when rst is asserted mid-period.

Verification
REQ-030 SHALL check reset/default: rst 2 cycles, en=1 -> tick high on cycles 4, 8, 12 after release; clk_out toggles at each, period 8 cycles.
REQ-031 SHALL check reload: div_load with div_in=6 at cycle 1 of a period (N=4) -> pend_vld=1, next tick still 4 cycles after prior tick, then 6-cycle spacing, div_cur=6.
REQ-032 SHALL check enable gating: en=0 for 3 cycles mid-period (N=4) -> tick delayed exactly 3 cycles, clk_out held, no tick while en=0.
REQ-033 SHALL check edge divisors: div 0 and div 1 -> tick stuck high with en=1; clk_out toggles every cycle.
REQ-034 SHALL check sclr: sclr at cnt=2 with pending 3 -> clk_out=0, div_cur=3, next tick 3 cycles later.
REQ-035 SHALL check reset mid-operation: rst with pend_vld=1 -> div_cur=4, pend_vld=0, tick spacing 4.
